// File: rtl/obm_dma.sv
// obm_dma: burst-copies one 256-byte CPU memory page into Object Memory.
// The CPU is halted for the whole copy. Each XFER cycle issues one memory read
// and writes the byte that the previous cycle's read returned.

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module obm_dma #(
  parameter int unsigned                   NUM_OBJECTS      = 64,
  parameter logic [`VRAM_ADDR_WIDTH-1:0]   OBM_BASE         = `VRAM_ADDR_WIDTH'('h800),
  parameter int unsigned                   MEM_READ_LATENCY = 1
) (
  input  logic                        cpu_clk,
  input  logic                        rst,
  input  logic                        trigger_write,
  input  logic [7:0]                  trigger_data,
  output logic [15:0]                 mem_address,
  output logic                        mem_read,
  input  logic [7:0]                  mem_data,
  output logic [`VRAM_ADDR_WIDTH-1:0] vram_address,
  output logic [7:0]                  vram_data,
  output logic                        write_enable,
  output logic                        SELECT_obm,
  output logic                        cpu_halt,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned NUM_BYTES  = 4 * NUM_OBJECTS;
  localparam int unsigned AW         = `VRAM_ADDR_WIDTH;
  localparam logic [7:0]  LAST_INDEX = 8'(NUM_BYTES - 1);

  // The write pipeline assumes read data arrives exactly one cycle after the read.
  if (MEM_READ_LATENCY != 1) begin : g_latency_check
    $error("obm_dma: only MEM_READ_LATENCY = 1 is supported");
  end
  if (NUM_BYTES == 0 || NUM_BYTES > 256) begin : g_length_check
    $error("obm_dma: transfer must fit inside one 256-byte page");
  end

  typedef enum logic [2:0] {StIdle, StAlign, StXfer, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [7:0]            index_q, index_d;
  logic [7:0]            page_q, page_d;
  logic                  mem_read_q, mem_read_d;
  logic [15:0]           mem_address_q, mem_address_d;
  logic                  write_q, write_d;
  logic [AW-1:0]         vram_address_q, vram_address_d;
  logic                  halt_q, halt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state: sequencing of the transfer and the source page/index counters.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    page_d  = page_q;
    unique case (state_q)
      StIdle: begin
        if (trigger_write) begin
          page_d  = trigger_data;
          index_d = '0;
          state_d = StAlign;
        end
      end
      StAlign: state_d = StXfer;
      StXfer: begin
        // Stop on the last index instead of wrapping into an extra read.
        if (index_q == LAST_INDEX) begin
          state_d = StDrain;
        end else begin
          index_d = index_q + 8'd1;
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        index_d = '0;
      end
      default: begin
        state_d = StIdle;
        index_d = '0;
      end
    endcase
  end

  // Output decode from the next state so every bus output comes straight off a flop.
  always_comb begin
    mem_read_d     = 1'b0;
    mem_address_d  = '0;
    write_d        = 1'b0;
    vram_address_d = '0;
    halt_d         = 1'b0;
    busy_d         = (state_d != StIdle);
    done_d         = (state_d == StDone);
    unique case (state_d)
      StAlign: halt_d = 1'b1;
      StXfer: begin
        halt_d        = 1'b1;
        mem_read_d    = 1'b1;
        mem_address_d = {page_d, index_d};
        // Index 0 has nothing in flight yet; later cycles write the previous byte.
        if (index_d != 8'd0) begin
          write_d        = 1'b1;
          vram_address_d = OBM_BASE + AW'(index_d) - AW'(1);
        end
      end
      StDrain: begin
        halt_d         = 1'b1;
        write_d        = 1'b1;
        vram_address_d = OBM_BASE + AW'(index_d);
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      index_q        <= '0;
      page_q         <= '0;
      mem_read_q     <= 1'b0;
      mem_address_q  <= '0;
      write_q        <= 1'b0;
      vram_address_q <= '0;
      halt_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      page_q         <= page_d;
      mem_read_q     <= mem_read_d;
      mem_address_q  <= mem_address_d;
      write_q        <= write_d;
      vram_address_q <= vram_address_d;
      halt_q         <= halt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign mem_address  = mem_address_q;
  assign mem_read     = mem_read_q;
  assign vram_address = vram_address_q;
  // mem_data is already registered by the memory; gating keeps the bus at 0 when idle.
  assign vram_data    = write_q ? mem_data : 8'h00;
  assign write_enable = write_q;
  assign SELECT_obm   = write_q;
  assign cpu_halt     = halt_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: doc/obm_dma.md
Name: obm_dma

Overview:
- CPU-side DMA engine that fills Object Memory (OBM) from a 256-byte page of CPU memory.
- It is the writer end of the VRAM interface that the foreground renderer reads: it drives vram_address, data, write_enable and SELECT_obm.
- A CPU write to the DMA trigger register starts a transfer. The CPU is halted for the duration, then released.
- This replaces 256 individual CPU stores with one 258-cycle burst, ideally issued during vblank.

Parameters:
- NUM_OBJECTS, 64, number of OBM objects; transfer length is NUM_BYTES = 4*NUM_OBJECTS.
- OBM_BASE, 12'h800, VRAM address of OBM byte 0.
- MEM_READ_LATENCY, 1, cycles from mem_read/mem_address to valid mem_data; only 1 is supported, other values raise $error.

Ports:
- cpu_clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- trigger_write  input  1  one-cycle strobe: CPU stored to the DMA register.
- trigger_data  input  8  source page; source address = {trigger_data, 8'(index)}.
- mem_address  output  16  CPU-memory read address.
- mem_read  output  1  read strobe.
- mem_data  input  8  read data, valid the cycle after mem_read.
- vram_address  output  `VRAM_ADDR_WIDTH  VRAM write address.
- vram_data  output  8  VRAM write data.
- write_enable  output  1  VRAM write strobe; the OBM side samples on negedge cpu_clk.
- SELECT_obm  output  1  OBM region select; high exactly when write_enable is high.
- cpu_halt  output  1  stalls the CPU while DMA owns the bus.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the last byte is written.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, index=0, page=0.
  - All outputs 0: mem_address=0, vram_address=0, vram_data=0.
  - Reset mid-transfer aborts immediately. No further writes; bytes already written stay in OBM.
- All outputs are registered on posedge cpu_clk, so they are stable at the negedge when OBM samples.
- States: IDLE, ALIGN, XFER, DRAIN, DONE.
- IDLE:
  - On trigger_write: latch page=trigger_data, index=0, go to ALIGN, assert cpu_halt the next cycle.
  - No other activity.
- ALIGN: one cycle with no bus activity, letting the triggering CPU store retire. Then go to XFER.
- XFER, one cycle per index, 0..NUM_BYTES-1:
  - mem_read=1, mem_address={page, index}.
  - If index>0: write_enable=1, SELECT_obm=1, vram_address=OBM_BASE+index-1, vram_data=mem_data (the byte read the previous cycle).
  - index increments, 8-bit unsigned. At index==NUM_BYTES-1, go to DRAIN; index does not wrap into a 257th read.
- DRAIN:
  - mem_read=0.
  - Writes the final byte: vram_address=OBM_BASE+NUM_BYTES-1, data=mem_data.
  - Go to DONE.
- DONE: done=1 and cpu_halt=0 for one cycle, then IDLE.
- Timing: trigger in cycle T puts ALIGN at T+1, XFER at T+2..T+NUM_BYTES+1, DRAIN at T+NUM_BYTES+2, DONE at T+NUM_BYTES+3. That is NUM_BYTES writes total, 258 cycles with cpu_halt high for the default.
- Address arithmetic: vram_address computed at width `VRAM_ADDR_WIDTH; mem_address low byte = index. For NUM_BYTES<256, the address never exceeds page boundary.
- trigger_write in any state other than IDLE is ignored; page does not change mid-transfer.
- Simultaneous trigger_write and DONE: ignored. A new transfer needs trigger in IDLE.
- Exactly one VRAM write per OBM byte, in ascending address order. write_enable is never high with SELECT_obm low.

Test Plan:
- Reset: hold rst=0 with trigger_write=1 → all outputs 0, state IDLE; release → still idle until next trigger.
- Full transfer: memory 0x0300..0x03FF = i^8'h5A; trigger_write with data 8'h03 →
  - cpu_halt high for 258 cycles;
  - 256 writes, OBM[k]=k^8'h5A, addresses 0x800..0x8FF in order;
  - done pulses once at T+259;
  - foreground OBM dump matches.
- Pipeline alignment: check cycle T+2 has mem_read with 0x0300 and no write; T+3 has read 0x0301 plus write 0x800 with byte 0; DRAIN writes 0x8FF with no read.
- Re-trigger while busy: trigger_write 8'h04 at cycle T+100 → ignored; all reads stay in page 0x03; length unchanged.
- Reset mid-transfer: rst=0 at cycle T+50 → write_enable drops asynchronously; OBM[0..47] updated, OBM[48..255] unchanged; next trigger restarts at index 0.
- Back-to-back: trigger in the cycle after done → second transfer starts normally and completes at the same latency.
